// File: rtl/key_debounce_multi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : key_pkg
//  Description : Shared types and helpers for the multi-channel key debouncer.
//                Per-channel state encoding, LED mode selectors and a
//                counter-width helper.
//  Revision    : 1.0  initial release
// ============================================================================
package key_pkg;

    // Per-channel debounce state, 3-bit encoding
    typedef enum logic [2:0] {
        KEY_IDLE       = 3'd0,
        KEY_PRESS_DB   = 3'd1,
        KEY_PRESSED    = 3'd2,
        KEY_RELEASE_DB = 3'd3
    } key_state_e;

    // LED toggle source selectors
    localparam int LED_ON_PRESS = 0;
    localparam int LED_ON_LONG  = 1;

    // Bits needed to hold values 0..max_count, never less than one bit
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_multi_channel.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_channel
//  Description : One key channel: 2-flop synchroniser, counter-based
//                press/release debounce FSM, long-press detection and an
//                LED toggle register. All outputs are registered.
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce_channel
    import key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 10,
    parameter int LONG_PRESS_CYCLES = 1000,
    parameter int LED_MODE          = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic led_o
);

    localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
    localparam int HOLD_W = cnt_width(LONG_PRESS_CYCLES);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    logic              s1_q, s2_q;
    key_state_e        state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              long_flag_q, long_flag_d;
    logic              level_q, level_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              long_q, long_d;
    logic              led_q, led_d;

    // Synchroniser resets to "released" so leaving reset never looks like a press
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= key_i;
            s2_q <= s1_q;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= KEY_IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            long_flag_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            led_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            long_flag_q <= long_flag_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            led_q       <= led_d;
        end
    end

    // Next-state logic; pulses default low so each lasts exactly one cycle
    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_flag_d = long_flag_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        led_d       = led_q;

        case (state_q)
            KEY_IDLE: begin
                if (!s2_q) begin
                    state_d  = KEY_PRESS_DB;
                    db_cnt_d = '0;
                end
            end
            KEY_PRESS_DB: begin
                if (s2_q) begin
                    state_d = KEY_IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = KEY_PRESSED;
                    press_d     = 1'b1;
                    hold_cnt_d  = '0;
                    long_flag_d = 1'b0;
                    if (LED_MODE == LED_ON_PRESS) begin
                        led_d = ~led_q;
                    end
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            KEY_PRESSED: begin
                if (s2_q) begin
                    state_d  = KEY_RELEASE_DB;
                    db_cnt_d = '0;
                end else if (!long_flag_q) begin
                    // Hold counter stops at its last value once the event fires
                    if (hold_cnt_q == HOLD_LAST) begin
                        long_d      = 1'b1;
                        long_flag_d = 1'b1;
                        if (LED_MODE == LED_ON_LONG) begin
                            led_d = ~led_q;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            KEY_RELEASE_DB: begin
                // A bounce back to pressed resumes the hold without a new press
                if (!s2_q) begin
                    state_d = KEY_PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = KEY_IDLE;
                    release_d = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = KEY_IDLE;
            end
        endcase

        level_d = (state_d == KEY_PRESSED) || (state_d == KEY_RELEASE_DB);
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = release_q;
    assign long_o    = long_q;
    assign led_o     = led_q;

endmodule
`default_nettype wire

// File: rtl/key_debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce_multi
//  Description : NUM_KEYS independent active-low push-button debouncers with
//                press/release/long-press pulses and per-key LED toggles.
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce_multi
    import key_pkg::*;
#(
    parameter int NUM_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES   = 10,
    parameter int LONG_PRESS_CYCLES = 1000,
    parameter int LED_MODE          = LED_ON_PRESS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press_pulse,
    output logic [NUM_KEYS-1:0] release_pulse,
    output logic [NUM_KEYS-1:0] long_pulse,
    output logic [NUM_KEYS-1:0] led
);

    // Channels share only clock and reset
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
        key_debounce_channel #(
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
            .LED_MODE         (LED_MODE)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .key_i    (key[g]),
            .level_o  (key_level[g]),
            .press_o  (press_pulse[g]),
            .release_o(release_pulse[g]),
            .long_o   (long_pulse[g]),
            .led_o    (led[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_multi.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_key_debounce_multi
//  Description : Self-checking bench for key_debounce_multi. Two instances
//                (LED on press / LED on long press) share one key bus and are
//                compared every cycle against a run-length reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_key_debounce_multi;

    localparam int N = 4;
    localparam int D = 10;
    localparam int L = 50;

    localparam int P_LVL = 0;
    localparam int P_PRS = 1;
    localparam int P_REL = 2;
    localparam int P_LNG = 3;
    localparam int P_LED = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] key;

    logic [N-1:0] lvl0, prs0, rel0, lng0, led0;
    logic [N-1:0] lvl1, prs1, rel1, lng1, led1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    key_debounce_multi #(
        .NUM_KEYS(N), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .LED_MODE(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .key(key),
        .key_level(lvl0), .press_pulse(prs0), .release_pulse(rel0),
        .long_pulse(lng0), .led(led0)
    );

    key_debounce_multi #(
        .NUM_KEYS(N), .DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .LED_MODE(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .key(key),
        .key_level(lvl1), .press_pulse(prs1), .release_pulse(rel1),
        .long_pulse(lng1), .led(led1)
    );

    // ------------------------------------------------------------------
    // Reference model: the FSM sees the key two edges late. A press is
    // accepted when the seen value has been low for D+1 consecutive edges
    // while released; a release likewise with high. Hold time counts edges
    // where the key was seen low on this and the previous edge while held.
    // ------------------------------------------------------------------
    logic [N-1:0] m_s1   = '1;
    logic [N-1:0] m_s2   = '1;
    logic [N-1:0] m_prev = '1;
    logic [N-1:0] m_lvl  = '0;
    logic [N-1:0] m_prs  = '0;
    logic [N-1:0] m_rel  = '0;
    logic [N-1:0] m_lng  = '0;
    logic [N-1:0] m_done = '0;
    logic [N-1:0] m_led0 = '0;
    logic [N-1:0] m_led1 = '0;
    int           m_run  [N];
    int           m_held [N];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1 = '1; m_s2 = '1; m_prev = '1;
            m_lvl = '0; m_prs = '0; m_rel = '0; m_lng = '0; m_done = '0;
            m_led0 = '0; m_led1 = '0;
            for (int i = 0; i < N; i++) begin
                m_run[i]  = 0;
                m_held[i] = 0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m_s2[i] == m_prev[i]) begin
                    if (m_run[i] < 1000000) m_run[i]++;
                end else begin
                    m_run[i] = 1;
                end
                m_prs[i] = 1'b0;
                m_rel[i] = 1'b0;
                m_lng[i] = 1'b0;
                if (!m_lvl[i] && !m_s2[i] && m_run[i] == D + 1) begin
                    m_lvl[i]  = 1'b1;
                    m_prs[i]  = 1'b1;
                    m_held[i] = 0;
                    m_done[i] = 1'b0;
                    m_led0[i] = ~m_led0[i];
                end else if (m_lvl[i] && m_s2[i] && m_run[i] == D + 1) begin
                    m_lvl[i] = 1'b0;
                    m_rel[i] = 1'b1;
                end else if (m_lvl[i] && !m_s2[i] && !m_prev[i] && !m_done[i]) begin
                    m_held[i]++;
                    if (m_held[i] == L) begin
                        m_lng[i]  = 1'b1;
                        m_done[i] = 1'b1;
                        m_led1[i] = ~m_led1[i];
                    end
                end
                m_prev[i] = m_s2[i];
            end
            m_s2 = m_s1;
            m_s1 = key;
        end
    end

    // ------------------------------------------------------------------
    // Hand-computed expectations, queued by the stimulus and checked by the
    // compare process at the next falling edge.
    // ------------------------------------------------------------------
    typedef struct {
        string        nm;
        int           dut;
        int           port;
        logic [N-1:0] exp;
    } lit_t;

    lit_t lits [64];
    int   lit_wr = 0;
    int   lit_rd = 0;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic logic [N-1:0] pick(input int dut, input int port);
        logic [N-1:0] v;
        v = '0;
        case (port)
            P_LVL:   v = (dut == 0) ? lvl0 : lvl1;
            P_PRS:   v = (dut == 0) ? prs0 : prs1;
            P_REL:   v = (dut == 0) ? rel0 : rel1;
            P_LNG:   v = (dut == 0) ? lng0 : lng1;
            default: v = (dut == 0) ? led0 : led1;
        endcase
        return v;
    endfunction

    task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    // Single compare process: model vs both DUTs every cycle, plus literals
    always @(negedge clk) begin
        chk("level0",   lvl0, m_lvl);
        chk("press0",   prs0, m_prs);
        chk("release0", rel0, m_rel);
        chk("long0",    lng0, m_lng);
        chk("led0",     led0, m_led0);
        chk("level1",   lvl1, m_lvl);
        chk("press1",   prs1, m_prs);
        chk("release1", rel1, m_rel);
        chk("long1",    lng1, m_lng);
        chk("led1",     led1, m_led1);
        while (lit_rd < lit_wr) begin
            chk(lits[lit_rd].nm, pick(lits[lit_rd].dut, lits[lit_rd].port), lits[lit_rd].exp);
            lit_rd++;
        end
    end

    task automatic lit(input string nm, input int dut, input int port, input logic [N-1:0] exp);
        lits[lit_wr].nm   = nm;
        lits[lit_wr].dut  = dut;
        lits[lit_wr].port = port;
        lits[lit_wr].exp  = exp;
        lit_wr++;
    endtask

    task automatic after_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    int cd [N];

    initial begin
        rst = 1'b1;
        key = '1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        after_edges(3);
        lit("reset_level", 0, P_LVL, 4'b0000);
        lit("reset_led",   0, P_LED, 4'b0000);

        // Clean press on key 0: low before E0, pulse after E12
        @(negedge clk); key[0] = 1'b0;
        after_edges(12);
        lit("press_E12_off", 0, P_PRS, 4'b0000);
        after_edges(1);
        lit("press_E13",     0, P_PRS, 4'b0001);
        lit("level_E13",     0, P_LVL, 4'b0001);
        lit("led_mode0",     0, P_LED, 4'b0001);
        lit("led_mode1_pr",  1, P_LED, 4'b0000);
        // Long press: 50 edges after the press pulse
        after_edges(49);
        lit("long_early",    0, P_LNG, 4'b0000);
        after_edges(1);
        lit("long_on_time",  0, P_LNG, 4'b0001);
        lit("led_mode1_lp",  1, P_LED, 4'b0001);
        lit("led_mode0_lp",  0, P_LED, 4'b0001);
        after_edges(100);
        // Release with the same latency
        @(negedge clk); key[0] = 1'b1;
        after_edges(12);
        lit("release_off",   0, P_REL, 4'b0000);
        after_edges(1);
        lit("release_on",    0, P_REL, 4'b0001);
        lit("level_rel",     0, P_LVL, 4'b0000);

        // Bounce on key 1: low 6, high 3, then stable low
        @(negedge clk); key[1] = 1'b0;
        repeat (6) @(negedge clk);
        key[1] = 1'b1;
        repeat (3) @(negedge clk);
        key[1] = 1'b0;
        after_edges(12);
        lit("bounce_press_off", 0, P_PRS, 4'b0000);
        after_edges(1);
        lit("bounce_press_on",  0, P_PRS, 4'b0010);
        after_edges(20);
        // Release glitch of 4 cycles must be rejected
        @(negedge clk); key[1] = 1'b1;
        repeat (4) @(negedge clk);
        key[1] = 1'b0;
        after_edges(30);
        lit("glitch_level", 0, P_LVL, 4'b0010);
        @(negedge clk); key[1] = 1'b1;
        after_edges(20);

        // Simultaneous press on all keys, staggered releases
        @(negedge clk); key = '0;
        after_edges(13);
        lit("simul_press", 0, P_PRS, 4'b1111);
        after_edges(10);
        for (int i = 0; i < N; i++) begin
            @(negedge clk); key[i] = 1'b1;
            repeat (2) @(negedge clk);
        end
        after_edges(30);

        // Async reset inside press debounce, keys stay held
        @(negedge clk); key = '0;
        after_edges(5);
        #1 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        after_edges(12);
        lit("rst_pdb_off", 0, P_PRS, 4'b0000);
        after_edges(1);
        lit("rst_pdb_on",  0, P_PRS, 4'b1111);
        // Async reset while pressed, keys released during reset
        after_edges(20);
        #1 rst = 1'b1;
        @(negedge clk);
        key = '1;
        @(negedge clk);
        rst = 1'b0;
        after_edges(30);
        lit("rst_pressed_level", 0, P_LVL, 4'b0000);

        // Randomised bouncing traffic on all channels
        for (int i = 0; i < N; i++) cd[i] = $urandom_range(1, 20);
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (cd[i] == 0) begin
                    key[i] = ~key[i];
                    case ($urandom_range(0, 2))
                        0:       cd[i] = $urandom_range(1, 5);
                        1:       cd[i] = $urandom_range(8, 14);
                        default: cd[i] = $urandom_range(20, 90);
                    endcase
                end else begin
                    cd[i]--;
                end
            end
        end

        repeat (3) @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
